// File: rtl/data_mem_ctrl_pkg.sv
// data_mem_ctrl_pkg: FSM state encoding and legal read-latency values for data_mem_ctrl.
package data_mem_ctrl_pkg;
    typedef enum logic {ST_CLEAR, ST_READY} state_t;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 2;
endpackage

// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bus between a requester and data_mem_ctrl.
interface data_mem_ctrl_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_WIDTH = 10
);
    logic req_valid;
    logic req_ready;
    logic req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic [WORD_SIZE/8-1:0] req_be;
    logic rsp_valid;
    logic [WORD_SIZE-1:0] rsp_data;
    logic init_done;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be,
        input req_ready, rsp_valid, rsp_data, init_done
    );
    modport slave (
        input req_valid, req_write, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_data, init_done
    );
endinterface

// File: rtl/data_mem_ctrl_mem_byte_lane.sv
// mem_byte_lane: one 8-bit synchronous single-port RAM lane with registered read data.
module mem_byte_lane #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);
    logic [7:0] mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (en && we) mem[addr] <= wdata;
    end
    // only the read register is reset; array contents survive reset
    always_ff @(posedge clk) begin
        if (rst) rdata <= '0;
        else if (en && !we) rdata <= mem[addr];
    end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-enabled word memory with post-reset zero fill and 1- or 2-cycle reads.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int READ_LATENCY = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic clk,
    input logic rst,
    data_mem_ctrl_if.slave bus
);
    localparam int LANES = WORD_SIZE / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(2**ADDR_WIDTH - 1);

    if (WORD_SIZE % 8 != 0 || WORD_SIZE < 8) begin : g_ws_chk
        $error("WORD_SIZE must be a positive multiple of 8");
    end
    if (READ_LATENCY != LAT_MIN && READ_LATENCY != LAT_MAX) begin : g_rl_chk
        $error("READ_LATENCY must be 1 or 2");
    end

    state_t state, state_nx;
    logic [ADDR_WIDTH-1:0] cnt, addr;
    logic [WORD_SIZE-1:0] lane_q;
    logic rst_q, clr_wr, ready, acc, rd_v1;

    always_ff @(posedge clk) begin
        if (rst) state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_READY;
        else state <= state_nx;
    end

    // rst_q keeps ready low for the cycle following a sampled reset
    always_comb begin
        clr_wr = state == ST_CLEAR && !rst;
        ready = state == ST_READY && !rst_q;
        state_nx = clr_wr && cnt == LAST ? ST_READY : state;
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            cnt <= '0;
            rd_v1 <= 1'b0;
        end else begin
            if (clr_wr) cnt <= cnt + 1'b1;
            rd_v1 <= acc && !bus.req_write;
        end
    end

    assign acc = bus.req_valid && ready;
    assign addr = clr_wr ? cnt : bus.req_addr;
    assign bus.req_ready = ready;
    assign bus.init_done = ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mem_byte_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
            .clk(clk),
            .rst(rst),
            .en(clr_wr || (acc && (!bus.req_write || bus.req_be[i]))),
            .we(clr_wr || bus.req_write),
            .addr(addr),
            .wdata(clr_wr ? 8'h00 : bus.req_wdata[8*i+:8]),
            .rdata(lane_q[8*i+:8])
        );
    end

    if (READ_LATENCY == LAT_MAX) begin : g_l2
        logic v2;
        logic [WORD_SIZE-1:0] d2;
        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= rd_v1;
                if (rd_v1) d2 <= lane_q;
            end
        end
        assign bus.rsp_valid = v2;
        assign bus.rsp_data = d2;
    end else begin : g_l1
        assign bus.rsp_valid = rd_v1;
        assign bus.rsp_data = lane_q;
    end
endmodule
